// File: rtl/dual_cam_pixel_feed_if.sv
// Pixel-request, camera FIFO read and underflow-status bundle for dual_cam_pixel_feed.
// master = VGA driver / FIFO side, slave = pixel feed.
interface dual_cam_pixel_feed_if;
  logic        vga_vs;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [15:0] pixel_data;
  logic        cam0_rd_en;
  logic [15:0] cam0_rd_data;
  logic        cam0_rd_empty;
  logic        cam1_rd_en;
  logic [15:0] cam1_rd_data;
  logic        cam1_rd_empty;
  logic        rd_load;
  logic        clr_uflow;
  logic        uflow_flag;
  logic [15:0] uflow_cnt;

  modport master (
    output vga_vs, data_req, pixel_xpos, cam0_rd_data, cam0_rd_empty,
           cam1_rd_data, cam1_rd_empty, clr_uflow,
    input  pixel_data, cam0_rd_en, cam1_rd_en, rd_load, uflow_flag, uflow_cnt
  );

  modport slave (
    input  vga_vs, data_req, pixel_xpos, cam0_rd_data, cam0_rd_empty,
           cam1_rd_data, cam1_rd_empty, clr_uflow,
    output pixel_data, cam0_rd_en, cam1_rd_en, rd_load, uflow_flag, uflow_cnt
  );
endinterface

// File: rtl/dual_cam_pixel_feed.sv
// Feeds the VGA driver: left half of each line from cam0 FIFO, right half from cam1 FIFO.
// Optional white centre divider on columns IMG_W-1 and IMG_W when DUAL_CAM_DIVIDER_EN is defined.
module dual_cam_pixel_feed #(
  parameter int          H_DISP      = 1024,
  parameter int          IMG_W       = 512,
  parameter int          LOAD_CYCLES = 16,
  parameter logic [15:0] UFLOW_COLOR = 16'hF800
) (
  input logic              vga_clk,
  input logic              sys_rst_n,
  dual_cam_pixel_feed_if.slave bus
);
  // state  | meaning
  // S_WAIT | black, waiting for the first field sync after reset
  // S_LOAD | rd_load asserted while the SDRAM read ports rewind
  // S_RUN  | serving pixel requests from the camera FIFOs
  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [7:0] LOAD_INIT = 8'(LOAD_CYCLES - 1);

  if (H_DISP != 2 * IMG_W) begin : g_bad_geom
    $error("dual_cam_pixel_feed: H_DISP must equal 2*IMG_W");
  end
  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 255) begin : g_bad_load
    $error("dual_cam_pixel_feed: LOAD_CYCLES out of range 1..255");
  end

  logic [1:0]  state;
  logic [7:0]  load_cnt;
  logic        vs_d1;
  logic        vs_fall;
  logic        run;
  logic        sel;
  logic        rd0;
  logic        rd1;
  logic        uflow;
  logic        req_d1;
  logic        sel_d1;
  logic        hit_d1;
  logic [15:0] pix_nxt;

  assign vs_fall = vs_d1 & ~bus.vga_vs;
  assign run     = (state == S_RUN);
  assign sel     = (bus.pixel_xpos >= 11'(IMG_W));
  assign rd0     = run & bus.data_req & ~sel & ~bus.cam0_rd_empty;
  assign rd1     = run & bus.data_req &  sel & ~bus.cam1_rd_empty;
  assign uflow   = run & bus.data_req & ~(rd0 | rd1);

  assign bus.cam0_rd_en = rd0;
  assign bus.cam1_rd_en = rd1;
  assign bus.rd_load    = (state == S_LOAD);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_WAIT;
      load_cnt <= 8'd0;
      vs_d1    <= 1'b1;
    end else begin
      vs_d1 <= bus.vga_vs;
      if (vs_fall) begin
        state    <= S_LOAD;
        load_cnt <= LOAD_INIT;
      end else if (state == S_LOAD) begin
        if (load_cnt == 8'd0) state <= S_RUN;
        else                  load_cnt <= load_cnt - 8'd1;
      end
    end
  end

`ifdef DUAL_CAM_DIVIDER_EN
  logic div_d1;
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div_d1 <= 1'b0;
    else            div_d1 <= (bus.pixel_xpos == 11'(IMG_W - 1)) | (bus.pixel_xpos == 11'(IMG_W));
  end
`endif

  // FIFO word appears the cycle after rd_en, so the mux uses the delayed select.
  always_comb begin
    pix_nxt = 16'd0;
    if (req_d1) begin
      if (hit_d1) pix_nxt = sel_d1 ? bus.cam1_rd_data : bus.cam0_rd_data;
      else        pix_nxt = UFLOW_COLOR;
`ifdef DUAL_CAM_DIVIDER_EN
      if (div_d1) pix_nxt = 16'hFFFF;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_d1         <= 1'b0;
      sel_d1         <= 1'b0;
      hit_d1         <= 1'b0;
      bus.pixel_data <= 16'd0;
    end else begin
      req_d1         <= run & bus.data_req;
      sel_d1         <= sel;
      hit_d1         <= rd0 | rd1;
      bus.pixel_data <= pix_nxt;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.uflow_flag <= 1'b0;
      bus.uflow_cnt  <= 16'd0;
    end else if (bus.clr_uflow) begin
      bus.uflow_flag <= 1'b0;
      bus.uflow_cnt  <= 16'd0;
    end else if (uflow) begin
      bus.uflow_flag <= 1'b1;
      if (bus.uflow_cnt != 16'hFFFF) bus.uflow_cnt <= bus.uflow_cnt + 16'd1;
    end
  end
endmodule
